// File: rtl/alien_laser_ctrl_pkg.sv
// Shared constants, slot-state encoding and small geometry helpers for the alien laser controller.
`timescale 1ns/1ps
package alien_laser_ctrl_pkg;

  localparam int NUM_LASERS = 3;
  localparam int COORD_W    = 10;

  localparam logic [9:0] LASER_SPEED   = 10'd4;
  localparam logic [9:0] LASER_HEIGHT  = 10'd10;
  localparam logic [9:0] SCREEN_BOTTOM = 10'd480;
  localparam logic [9:0] PARK_X        = 10'd0;
  localparam logic [9:0] PARK_Y        = 10'd0;
  localparam logic [9:0] SHIP_Y        = 10'd440;
  localparam logic [9:0] SHIP_W        = 10'd32;
  localparam logic [9:0] SHIP_H        = 10'd16;
  localparam logic [7:0] FIRE_COOLDOWN = 8'd30;
  localparam logic [7:0] LFSR_SEED     = 8'hA5;

  typedef enum logic {
    SLOT_IDLE   = 1'b0,
    SLOT_ACTIVE = 1'b1
  } slot_state_e;

  // 11-bit sum so a bolt near the top of the 10-bit range cannot wrap past the bottom test.
  function automatic logic reaches_bottom(input logic [9:0] y);
    return ({1'b0, y} + {1'b0, LASER_SPEED} + {1'b0, LASER_HEIGHT}) >= {1'b0, SCREEN_BOTTOM};
  endfunction

  function automatic logic in_ship_zone(input logic [9:0] x, input logic [9:0] y,
                                        input logic [9:0] ship_x);
    logic [10:0] tip;
    tip = {1'b0, y} + {1'b0, LASER_HEIGHT};
    return (tip >= {1'b0, SHIP_Y}) && (tip < ({1'b0, SHIP_Y} + {1'b0, SHIP_H})) &&
           ({1'b0, x} >= {1'b0, ship_x}) && ({1'b0, x} < ({1'b0, ship_x} + {1'b0, SHIP_W}));
  endfunction

  function automatic logic [NUM_LASERS-1:0] lowest_set(input logic [NUM_LASERS-1:0] v);
    return v & (~v + {{(NUM_LASERS-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/alien_laser_ctrl_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that jitters the alien fire cooldown.
`timescale 1ns/1ps
module lfsr8
  import alien_laser_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  logic [7:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) q_q <= LFSR_SEED;
    else     q_q <= {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
  end

  assign q = q_q;

endmodule

// File: rtl/alien_laser_ctrl.sv
// Alien laser bolt controller: launches, moves and retires three bolt slots.
// Optional ship collision is enabled by defining ALIEN_LASER_SHIP_HIT_EN.
`timescale 1ns/1ps
module alien_laser_ctrl
  import alien_laser_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        restart,
  input  logic        tick,
  input  logic [9:0]  originX,
  input  logic [9:0]  originY,
  input  logic        originValid,
  input  logic [11:0] alienLaserHit,
  input  logic [9:0]  shipX,
  output logic [29:0] alienLaserXcoord,
  output logic [29:0] alienLaserYcoord,
  output logic [2:0]  laserActive,
  output logic        fireAck,
  output logic        shipHit
);

  logic [7:0]            lfsr_q;
  logic [7:0]            cd_q, cd_d;
  logic                  fire_ack_q, ship_hit_q;
  logic                  clear_all, launch;
  logic [NUM_LASERS-1:0] idle_vec, launch_sel, ship_strike;
  logic                  unused_ok;

  lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // mode low or a restart pulse behaves like a game reset, except the LFSR keeps running.
  assign clear_all  = !mode || restart;
  assign launch_sel = lowest_set(idle_vec);
  assign launch     = !clear_all && (cd_q == 8'd0) && originValid && (|idle_vec);

  for (genvar g = 0; g < NUM_LASERS; g++) begin : g_slot
    slot_state_e state_q;
    logic [9:0]  x_q, y_q;

`ifdef ALIEN_LASER_SHIP_HIT_EN
    assign ship_strike[g] = (state_q == SLOT_ACTIVE) && !alienLaserHit[g] &&
                            in_ship_zone(x_q, y_q, shipX);
`else
    assign ship_strike[g] = 1'b0;
`endif

    always_ff @(posedge clk) begin
      if (rst || clear_all) begin
        state_q <= SLOT_IDLE;
        x_q     <= PARK_X;
        y_q     <= PARK_Y;
      end else if (state_q == SLOT_IDLE) begin
        if (launch && launch_sel[g]) begin
          state_q <= SLOT_ACTIVE;
          x_q     <= originX;
          y_q     <= originY;
        end
      end else if (alienLaserHit[g] || ship_strike[g] || (tick && reaches_bottom(y_q))) begin
        state_q <= SLOT_IDLE;
        x_q     <= PARK_X;
        y_q     <= PARK_Y;
      end else if (tick) begin
        y_q <= y_q + LASER_SPEED;
      end
    end

    assign idle_vec[g]                  = (state_q == SLOT_IDLE);
    assign laserActive[g]               = (state_q == SLOT_ACTIVE);
    assign alienLaserXcoord[10*g +: 10] = x_q;
    assign alienLaserYcoord[10*g +: 10] = y_q;
  end

  always_comb begin
    cd_d = cd_q;
    if (launch)                     cd_d = FIRE_COOLDOWN + {4'b0, lfsr_q[3:0]};
    else if (tick && cd_q != 8'd0)  cd_d = cd_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      cd_q       <= FIRE_COOLDOWN;
      fire_ack_q <= 1'b0;
      ship_hit_q <= 1'b0;
    end else begin
      cd_q       <= cd_d;
      fire_ack_q <= launch;
      ship_hit_q <= |ship_strike;
    end
  end

  assign fireAck = fire_ack_q;
  assign shipHit = ship_hit_q;

`ifdef ALIEN_LASER_SHIP_HIT_EN
  assign unused_ok = ^{alienLaserHit[11:3], lfsr_q[7:4]};
`else
  assign unused_ok = ^{alienLaserHit[11:3], lfsr_q[7:4], shipX};
`endif

endmodule
